// File: rtl/counter_pkg.sv
// Shared types and constants for the counter sequencer and its datapath.
package counter_pkg;

  localparam int N_DEFAULT = 4;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

endpackage

// File: rtl/up_counter_core.sv
// N-bit up-counter datapath; clear takes priority over enable.
module up_counter_core
  import counter_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic         clear,
  output logic [N-1:0] out
);

  logic [N-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + N'(1);
    end
  end

  // NOTE: clocked state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign out = count_q;

endmodule

// File: rtl/counter_seq_ctrl.sv
// Start/stop/pause sequencer with programmable terminal value and one-shot or
// periodic reload; the only driver of the up-counter's enable and clear.
module counter_seq_ctrl
  import counter_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         stop,
  input  logic         pause,
  input  logic         mode,
  input  logic [N-1:0] limit,
  output logic [N-1:0] count,
  output logic         busy,
  output logic         done,
  output logic [1:0]   state
);

  state_t       state_q, state_d;
  logic [N-1:0] limit_q, limit_d;
  logic         mode_q, mode_d;
  logic         done_q, done_d;
  logic         busy_q, busy_d;
  logic         cnt_en, cnt_clr;
  logic         at_limit;

  assign at_limit = (count == limit_q);

  // NOTE: every signal gets a default first so no path leaves it unassigned
  // (which would infer a latch).
  always_comb begin
    state_d = state_q;
    limit_d = limit_q;
    mode_d  = mode_q;
    done_d  = 1'b0;
    cnt_en  = 1'b0;
    cnt_clr = 1'b0;

    if (stop) begin
      state_d = ST_IDLE;
      cnt_clr = 1'b1;
    end else if (start) begin
      // Restart from any state; a pending terminal event is simply dropped.
      limit_d = limit;
      mode_d  = mode;
      cnt_clr = 1'b1;
      state_d = ST_RUN;
    end else begin
      case (state_q)
        ST_IDLE: ;
        ST_RUN: begin
          if (pause) begin
            state_d = ST_PAUSE;
          end else if (!at_limit) begin
            cnt_en = 1'b1;
          end else begin
            done_d = 1'b1;
            if (mode_q == MODE_PERIODIC) begin
              cnt_clr = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        ST_PAUSE: begin
          if (!pause) state_d = ST_RUN;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    busy_d = (state_d == ST_RUN) || (state_d == ST_PAUSE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      limit_q <= '0;
      mode_q  <= MODE_ONESHOT;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      limit_q <= limit_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  up_counter_core #(.N(N)) u_core (
    .clk    (clk),
    .rst    (rst),
    .enable (cnt_en),
    .clear  (cnt_clr),
    .out    (count)
  );

  assign busy  = busy_q;
  assign done  = done_q;
  assign state = state_q;

endmodule

// File: doc/counter_seq_ctrl.md
Name: counter_seq_ctrl

Overview:
- Sequencer for the team's N-bit up-counter datapath.
- Adds start/stop/pause control, a programmable terminal value, and one-shot or periodic (auto-reload) operation.
- Produces a one-cycle terminal-count pulse for downstream timing logic.
- Sits between software/FSM-level control and the raw counter; it is the only agent that drives the counter's enable and clear.

Parameters:
- N, 4, counter and terminal-value width in bits

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  command: latch limit, clear count, begin counting
- stop  in  1  command: abort, clear count, return to IDLE
- pause  in  1  level: hold count while high (RUN/PAUSE only)
- mode  in  1  0 = one-shot, 1 = periodic; sampled with start
- limit  in  N  terminal value L; sampled with start
- count  out  N  current counter value
- busy  out  1  high in RUN or PAUSE
- done  out  1  one-cycle terminal-count pulse, registered
- state  out  2  current FSM state (debug)

Behaviour:
- Reset: synchronous, active-high, single clock clk. On a rst edge: state=IDLE, count=0, busy=0, done=0, latched limit=0, latched mode=0.
- Command priority at any edge: rst > stop > start > pause > counting.
- States:
  - IDLE=0, RUN=1, PAUSE=2; encoding 3 is illegal and goes to IDLE next edge.
  - IDLE: start -> latch limit/mode, count=0, go RUN. Otherwise hold; count keeps its last value.
  - RUN: pause high -> PAUSE, count held, no increment, no done, even if count==L this cycle. Otherwise, if count != L, count+1.
  - RUN, count == L, periodic: count=0, stay RUN, done=1 next cycle.
  - RUN, count == L, one-shot: count holds L, go IDLE, done=1 next cycle, busy=0 next cycle.
  - PAUSE: pause low -> RUN; count held throughout.
  - stop in any state: IDLE, count=0, done=0, no terminal pulse.
  - start in RUN or PAUSE: restart. Relatch limit/mode, count=0, RUN. Any pending terminal event is discarded.
- Timing: start sampled at edge k gives count=0 after edge k and count=j after edge k+j. done is high during the cycle after edge k+L+1.
  - Periodic period is L+1 cycles.
  - The done pulse is exactly one cycle wide.
- Arithmetic: count is unsigned N-bit and never exceeds L, so no overflow. L = 2^N-1 gives a full-range period of 2^N.
- L=0: periodic asserts done every cycle with count stuck at 0. One-shot asserts done once, 2 cycles after start.
- limit/mode changes while busy have no effect until the next start.
- busy and state are registered; outputs have no combinational path from inputs.

Decomposition:
- Shared package counter_pkg:
  - state localparams ST_IDLE, ST_RUN, ST_PAUSE
  - MODE_ONESHOT=0, MODE_PERIODIC=1
  - default width N=4
- Sub-module up_counter_core: the datapath.
  - Ports: clk, rst, enable, clear, out.
  - clear has priority over enable.
  - The controller drives enable and clear; count=out.
- The controller holds only the FSM, the limit/mode registers, the comparator and the done register.

Test Plan:
- Reset: hold rst 3 cycles mid-RUN (count=5) -> count=0, busy=0, done=0, state=IDLE on the next edge.
- One-shot, L=9: start one cycle -> count runs 0..9. done high for exactly 1 cycle, 11 cycles after start. busy falls with done; count stays 9.
- Periodic, L=3 over 20 cycles -> count pattern 0,1,2,3,0,... and done every 4 cycles. Also run L=15 -> period 16.
- Pause: periodic L=7, pause high 5 cycles at count=4 -> count holds 4, state=PAUSE. Resumes 5,6,7; no done during pause. Also pause asserted exactly at count=7 -> no done until released.
- Stop/restart: stop at count=6 -> IDLE, count=0, no done. Then start with L=2 while RUN at count=1 -> count=0 next edge, new period 3.
- Edge cases:
  - L=0 periodic -> done constant high after the first pulse.
  - start and stop in the same cycle -> stop wins, IDLE.
  - limit changed mid-RUN -> ignored.
